// File: rtl/dl166_pkg.sv
// rtl/dl166_pkg.sv - shared constants, loader state encoding and checksum helper
package dl166_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_HI = 3'd1,
        S_LOAD_LO = 3'd2,
        S_WRITE   = 3'd3,
        S_CHK_HI  = 3'd4,
        S_CHK_LO  = 3'd5,
        S_RUN     = 3'd6,
        S_ERR     = 3'd7
    } loader_state_t;

    // The image is good when the running byte sum plus the checksum byte wraps to zero.
    function automatic logic chk_ok(input logic [DW-1:0] sum, input logic [DW-1:0] chk);
        logic [DW-1:0] total;
        total = sum + chk;
        return (total == '0);
    endfunction

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program store, synchronous write port and asynchronous fetch port
module prog_ram
    import dl166_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - fills the program store from a nibble stream and releases the core on a good checksum
module prog_loader
    import dl166_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          nib_valid,
    input  logic [3:0]    nib,
    output logic          nib_ready,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          cpu_rst_n,
    output logic          busy,
    output logic          loaded,
    output logic          err
);

    loader_state_t state, state_n;
    logic [AW-1:0] ptr;
    logic [DW-1:0] sum;
    logic [3:0]    hi;
    logic [3:0]    lo;
    logic          xfer;

    assign xfer = nib_valid && nib_ready;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_RUN, S_ERR: if (start) state_n = S_LOAD_HI;
            S_LOAD_HI:            if (xfer)  state_n = S_LOAD_LO;
            S_LOAD_LO:            if (xfer)  state_n = S_WRITE;
            S_WRITE:              state_n = (ptr == AW'(DEPTH - 1)) ? S_CHK_HI : S_LOAD_HI;
            S_CHK_HI:             if (xfer)  state_n = S_CHK_LO;
            S_CHK_LO:             if (xfer)  state_n = chk_ok(sum, {hi, nib}) ? S_RUN : S_ERR;
            default:              state_n = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet track state exactly.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            sum       <= '0;
            hi        <= '0;
            lo        <= '0;
            nib_ready <= 1'b0;
            busy      <= 1'b0;
            cpu_rst_n <= 1'b0;
            loaded    <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            nib_ready <= state_n inside {S_LOAD_HI, S_LOAD_LO, S_CHK_HI, S_CHK_LO};
            busy      <= state_n inside {S_LOAD_HI, S_LOAD_LO, S_WRITE, S_CHK_HI, S_CHK_LO};
            cpu_rst_n <= (state_n == S_RUN);
            loaded    <= (state_n == S_RUN);
            err       <= (state_n == S_ERR);
            case (state)
                S_IDLE, S_RUN, S_ERR: begin
                    if (start) begin
                        ptr <= '0;
                        sum <= '0;
                    end
                end
                S_LOAD_HI, S_CHK_HI: if (xfer) hi <= nib;
                S_LOAD_LO, S_CHK_LO: if (xfer) lo <= nib;
                S_WRITE: begin
                    sum <= sum + {hi, lo};
                    ptr <= ptr + AW'(1);
                end
                default: ;
            endcase
        end
    end

    prog_ram u_ram (
        .clk (clk),
        .we  (state == S_WRITE),
        .wa  (ptr),
        .wd  ({hi, lo}),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader against a nibble-count model
module tb_prog_loader;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_ERR  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       nib_valid = 1'b0;
    logic [3:0] nib = 4'h0;
    logic       nib_ready;
    logic [3:0] rd_addr = 4'h0;
    logic [7:0] rd_data;
    logic       cpu_rst_n, busy, loaded, err;

    int n_checks = 0;
    int n_fail = 0;

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .nib_valid (nib_valid),
        .nib       (nib),
        .nib_ready (nib_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .loaded    (loaded),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Model: counts accepted nibbles; every second program nibble is followed by one write bubble.
    int         m_mode = M_IDLE;
    int         m_cnt = 0;
    bit         m_bub = 1'b0;
    bit         m_live = 1'b0;
    logic [3:0] m_nibs [34];
    logic [7:0] mmem [16];

    initial begin
        logic [7:0] s;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_mode = M_IDLE; m_cnt = 0; m_bub = 1'b0; m_live = 1'b1;
            end else if (m_live) begin
                if (m_mode != M_LOAD) begin
                    if (start) begin
                        m_mode = M_LOAD; m_cnt = 0; m_bub = 1'b0;
                    end
                end else if (m_bub) begin
                    m_bub = 1'b0;
                    mmem[m_cnt/2 - 1] = {m_nibs[m_cnt-2], m_nibs[m_cnt-1]};
                end else if (nib_valid) begin
                    m_nibs[m_cnt] = nib;
                    m_cnt++;
                    if (m_cnt == 34) begin
                        s = 8'h00;
                        for (int k = 0; k < 17; k++) s = s + {m_nibs[2*k], m_nibs[2*k+1]};
                        m_mode = (s == 8'h00) ? M_RUN : M_ERR;
                    end else if (m_cnt % 2 == 0) begin
                        m_bub = 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("outputs{cpu_rst_n,busy,loaded,err,nib_ready}",
                  {27'd0, cpu_rst_n, busy, loaded, err, nib_ready},
                  {27'd0, m_mode == M_RUN, m_mode == M_LOAD, m_mode == M_RUN,
                   m_mode == M_ERR, (m_mode == M_LOAD) && !m_bub});
        end
    end

    bit mon_en = 1'b0;
    int busy_cnt = 0;
    int rdy_lo_cnt = 0;
    always @(negedge clk) begin
        if (mon_en && busy) begin
            busy_cnt++;
            if (!nib_ready) rdy_lo_cnt++;
        end
    end

    logic [7:0] cur_w [16];
    logic [3:0] cur_nibs [34];

    task automatic build_nibs(input logic [7:0] chk);
        for (int i = 0; i < 16; i++) begin
            cur_nibs[2*i]   = cur_w[i][7:4];
            cur_nibs[2*i+1] = cur_w[i][3:0];
        end
        cur_nibs[32] = chk[7:4];
        cur_nibs[33] = chk[3:0];
    endtask

    task automatic send_nib(input logic [3:0] v, input int gap);
        int guard;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk); nib_valid = 1'b0; start = 1'b0;
        end
        @(negedge clk);
        start = 1'b0; nib_valid = 1'b1; nib = v;
        guard = 0;
        while (!nib_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("nib_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1; nib_valid = 1'b0;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_nibs(input int n, input int maxgap, input int poke);
        for (int i = 0; i < n; i++) begin
            send_nib(cur_nibs[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
            if (i == poke) begin
                @(negedge clk); nib_valid = 1'b0; start = 1'b1;
            end
        end
        @(negedge clk); nib_valid = 1'b0; start = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!(loaded || err) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk); rd_addr = a; #1;
        check(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic check_mem();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk); rd_addr = 4'(a); #1;
            check("mem_image", {24'd0, rd_data}, {24'd0, mmem[a]});
        end
    endtask

    task automatic full_load(input logic [7:0] chk, input int maxgap, input int poke);
        build_nibs(chk);
        start_pulse();
        send_nibs(34, maxgap, poke);
        wait_done();
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) cur_w[i] = 8'(i + 1);
        mon_en = 1'b1; busy_cnt = 0; rdy_lo_cnt = 0;
        full_load(8'h78, 0, -1);
        mon_en = 1'b0;
        check("load_busy_cycles", busy_cnt, 32'd51);
        check("write_bubbles", rdy_lo_cnt, 32'd16);
        check("good_load_flags", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'b10100);
        read_check("rd_addr5", 4'd5, 8'h06);
        read_check("rd_addr15", 4'd15, 8'h10);
        check_mem();

        full_load(8'h79, 0, -1);
        check("bad_chk_flags", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'b00010);
        full_load(8'h78, 0, -1);
        check("recover_flags", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'b10100);

        full_load(8'h78, 5, -1);
        check("gapped_load_flags", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'b10100);
        read_check("gapped_rd_addr5", 4'd5, 8'h06);
        check_mem();

        build_nibs(8'h78);
        start_pulse();
        check("reload_from_run", {29'd0, cpu_rst_n, busy, loaded}, 32'b010);
        send_nibs(34, 0, 6);
        wait_done();
        check("reload_ignored_start", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'b10100);
        check_mem();

        for (int i = 0; i < 16; i++) cur_w[i] = 8'hA0 + 8'(i);
        build_nibs(8'h88);
        start_pulse();
        send_nibs(16, 0, -1);
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        check("midload_reset", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'd0);
        full_load(8'h88, 2, -1);
        check("after_reset_load", {27'd0, cpu_rst_n, busy, loaded, err, nib_ready}, 32'b10100);
        read_check("b_rd_addr0", 4'd0, 8'hA0);
        read_check("b_rd_addr15", 4'd15, 8'hAF);
        check_mem();

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
